// File: rtl/collision_if.sv
// Purpose: row-scan / frog-position inputs and game-over outputs of collision_detect.
// Ports (signals):
//   row_valid, row_idx, road_pixels   road/lane row stream
//   frog_row, frog_pixels, respawn    frog position, mask and respawn pulse
//   hit, hit_row, life_lost, lives_left  collision results
// master drives the stream and frog signals; slave is the collision detector.
interface collision_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ROW_W = 4
);
  logic             row_valid;
  logic [ROW_W-1:0] row_idx;
  logic [WIDTH-1:0] road_pixels;
  logic [ROW_W-1:0] frog_row;
  logic [WIDTH-1:0] frog_pixels;
  logic             respawn;
  logic             hit;
  logic [ROW_W-1:0] hit_row;
  logic             life_lost;
  logic [1:0]       lives_left;

  modport master (
    output row_valid, row_idx, road_pixels, frog_row, frog_pixels, respawn,
    input  hit, hit_row, life_lost, lives_left
  );

  modport slave (
    input  row_valid, row_idx, road_pixels, frog_row, frog_pixels, respawn,
    output hit, hit_row, life_lost, lives_left
  );
endinterface

// File: rtl/collision_detect.sv
// Purpose: compares the road row the frog sits on against the frog mask and
//   latches a sticky game-over level, with a spawn grace period.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    collision_if.slave: row stream + frog inputs, hit/hit_row/
//          life_lost/lives_left outputs (all registered)
// Optional feature: COLLIDE_LIVES_EN enables a lives counter; without it
//   life_lost and lives_left are tied 0 and the first collision is fatal.
module collision_detect #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned ROW_W        = 4,
  parameter int unsigned GRACE_CYCLES = 8,
  parameter int unsigned LIVES        = 3
) (
  input logic        clk,
  input logic        reset,
  collision_if.slave bus
);

  localparam int unsigned CNT_W = (GRACE_CYCLES > 0) ? $clog2(GRACE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (GRACE_CYCLES > 0) ? CNT_W'(GRACE_CYCLES - 1) : '0;

  typedef enum logic [1:0] {GRACE, WATCH, DEAD} state_t;

  // Entry state after reset, respawn or a non-fatal collision.
  localparam state_t START = (GRACE_CYCLES == 0) ? WATCH : GRACE;

  // lives_left is two bits wide.
  if (LIVES < 1 || LIVES > 3) begin : g_lives_range
    $error("collision_detect: LIVES must be in 1..3");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic [ROW_W-1:0] hit_row_q, hit_row_d;
  logic             ovl_c;

`ifdef COLLIDE_LIVES_EN
  logic [1:0] lives_q, lives_d;
  logic       life_lost_q, life_lost_d;
`endif

  // Frog row is on the bus and at least one hazard pixel covers the frog.
  assign ovl_c = bus.row_valid && (bus.row_idx == bus.frog_row) &&
                 (|(bus.road_pixels & bus.frog_pixels));

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hit_d     = hit_q;
    hit_row_d = hit_row_q;
`ifdef COLLIDE_LIVES_EN
    lives_d     = lives_q;
    life_lost_d = 1'b0;
`endif
    case (state_q)
      GRACE: begin
        if (bus.respawn) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = WATCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WATCH: begin
        // A collision takes priority over a simultaneous respawn.
        if (ovl_c) begin
`ifdef COLLIDE_LIVES_EN
          if (lives_q > 2'd1) begin
            lives_d     = lives_q - 2'd1;
            life_lost_d = 1'b1;
            state_d     = START;
            cnt_d       = '0;
          end else begin
            lives_d   = 2'd0;
            state_d   = DEAD;
            hit_d     = 1'b1;
            hit_row_d = bus.row_idx;
          end
`else
          state_d   = DEAD;
          hit_d     = 1'b1;
          hit_row_d = bus.row_idx;
`endif
        end else if (bus.respawn) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      DEAD: begin
        state_d = DEAD;
      end
      default: begin
        state_d = START;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= START;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      hit_row_q <= '0;
`ifdef COLLIDE_LIVES_EN
      lives_q     <= 2'(LIVES);
      life_lost_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      hit_row_q <= hit_row_d;
`ifdef COLLIDE_LIVES_EN
      lives_q     <= lives_d;
      life_lost_q <= life_lost_d;
`endif
    end
  end

  assign bus.hit     = hit_q;
  assign bus.hit_row = hit_row_q;
`ifdef COLLIDE_LIVES_EN
  assign bus.life_lost  = life_lost_q;
  assign bus.lives_left = lives_q;
`else
  assign bus.life_lost  = 1'b0;
  assign bus.lives_left = 2'd0;
`endif

endmodule

// File: tb/tb_collision_detect.sv
// Bench for collision_detect: two instances (grace 8 and grace 0) share one
// stimulus stream; a reference model tracks remaining grace, lives and death.
module tb_collision_detect;

`ifdef COLLIDE_LIVES_EN
  localparam bit LEN = 1'b1;
`else
  localparam bit LEN = 1'b0;
`endif
  localparam int LIVES_INIT = LEN ? 3 : 0;
  localparam int GR [2] = '{8, 0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        row_valid = 1'b0;
  logic [3:0]  row_idx = '0;
  logic [15:0] road_pixels = '0;
  logic [3:0]  frog_row = 4'd5;
  logic [15:0] frog_pixels = 16'h0100;
  logic        respawn = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  collision_if #(.WIDTH(16), .ROW_W(4)) if0 ();
  collision_if #(.WIDTH(16), .ROW_W(4)) if1 ();

  assign if0.row_valid = row_valid;   assign if1.row_valid = row_valid;
  assign if0.row_idx = row_idx;       assign if1.row_idx = row_idx;
  assign if0.road_pixels = road_pixels; assign if1.road_pixels = road_pixels;
  assign if0.frog_row = frog_row;     assign if1.frog_row = frog_row;
  assign if0.frog_pixels = frog_pixels; assign if1.frog_pixels = frog_pixels;
  assign if0.respawn = respawn;       assign if1.respawn = respawn;

  collision_detect #(.WIDTH(16), .ROW_W(4), .GRACE_CYCLES(8), .LIVES(3)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  collision_detect #(.WIDTH(16), .ROW_W(4), .GRACE_CYCLES(0), .LIVES(3)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  // Reference model: grace expressed as remaining cycles of invulnerability.
  bit         m_ready = 1'b0;
  bit         m_hit [2];
  logic [3:0] m_row [2];
  bit         m_ll [2];
  int         m_lives [2];
  int         m_grace [2];

  always @(posedge clk) begin
    bit ovl;
    ovl = row_valid && (row_idx == frog_row) && ((road_pixels & frog_pixels) != 16'h0);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_grace[i] = GR[i];
        m_hit[i]   = 1'b0;
        m_row[i]   = 4'd0;
        m_ll[i]    = 1'b0;
        m_lives[i] = LIVES_INIT;
      end else begin
        m_ll[i] = 1'b0;
        if (!m_hit[i]) begin
          if (m_grace[i] > 0) begin
            m_grace[i] = respawn ? GR[i] : m_grace[i] - 1;
          end else if (ovl) begin
            if (LEN && m_lives[i] > 1) begin
              m_lives[i] = m_lives[i] - 1;
              m_ll[i]    = 1'b1;
              m_grace[i] = GR[i];
            end else begin
              m_hit[i]   = 1'b1;
              m_row[i]   = row_idx;
              m_lives[i] = 0;
            end
          end else if (respawn) begin
            m_grace[i] = GR[i];
          end
        end
      end
    end
    if (reset) m_ready = 1'b1;
  end

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input logic h, input logic [3:0] hr,
                          input logic ll, input logic [1:0] lv);
    chk("hit", i, 32'(h), 32'(m_hit[i]));
    chk("hit_row", i, 32'(hr), 32'(m_row[i]));
    chk("life_lost", i, 32'(ll), 32'(m_ll[i]));
    chk("lives_left", i, 32'(lv), 32'(m_lives[i]));
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ready) begin
      cmp_inst(0, if0.hit, if0.hit_row, if0.life_lost, if0.lives_left);
      cmp_inst(1, if1.hit, if1.hit_row, if1.life_lost, if1.lives_left);
    end
  end

  task automatic step(input bit rst, input bit rv, input logic [3:0] ri,
                      input logic [15:0] rp, input logic [3:0] fr,
                      input logic [15:0] fp, input bit rs);
    reset = rst; row_valid = rv; row_idx = ri; road_pixels = rp;
    frog_row = fr; frog_pixels = fp; respawn = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 4'd0, 16'h0, 4'd5, 16'h0100, 1'b0);
  endtask

  task automatic hit5();
    step(1'b0, 1'b1, 4'd5, 16'h0100, 4'd5, 16'h0100, 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd5, 16'h0100, 1'b0);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd5, 16'h0100, 1'b0);
    chk("rst_hit", 0, 32'(if0.hit), 32'd0);
    chk("rst_hit_row", 0, 32'(if0.hit_row), 32'd0);
    chk("rst_life_lost", 0, 32'(if0.life_lost), 32'd0);
    chk("rst_lives", 0, 32'(if0.lives_left), 32'(LIVES_INIT));
    chk("rst_hit", 1, 32'(if1.hit), 32'd0);

`ifndef COLLIDE_LIVES_EN
    hit5();                                   // cycle 0: grace for inst0, fatal for inst1
    chk("grace0_hit", 0, 32'(if0.hit), 32'd0);
    chk("nograce_hit", 1, 32'(if1.hit), 32'd1);
    chk("nograce_row", 1, 32'(if1.hit_row), 32'd5);
    idle(2);
    hit5();                                   // cycle 3
    chk("grace3_hit", 0, 32'(if0.hit), 32'd0);
    idle(4);                                  // cycles 4..7
    step(1'b0, 1'b1, 4'd4, 16'hFFFF, 4'd5, 16'h0100, 1'b0);   // cycle 8, wrong row
    chk("wrong_row", 0, 32'(if0.hit), 32'd0);
    step(1'b0, 1'b1, 4'd5, 16'hFEFF, 4'd5, 16'h0100, 1'b0);   // cycle 9, no bit overlap
    chk("no_overlap", 0, 32'(if0.hit), 32'd0);
    idle(2);
    hit5();                                   // cycle 12
    chk("watch_hit", 0, 32'(if0.hit), 32'd1);
    chk("watch_row", 0, 32'(if0.hit_row), 32'd5);
    step(1'b0, 1'b1, 4'd7, 16'hFFFF, 4'd7, 16'h0080, 1'b1);
    chk("dead_hit", 0, 32'(if0.hit), 32'd1);
    chk("dead_row", 0, 32'(if0.hit_row), 32'd5);
    step(1'b1, 1'b0, 4'd0, 16'h0, 4'd5, 16'h0100, 1'b0);
    chk("rst_clears_hit", 0, 32'(if0.hit), 32'd0);
    hit5();                                   // cycle 0 after reset
    chk("regrace_hit", 0, 32'(if0.hit), 32'd0);
    idle(9);                                  // cycles 1..9, WATCH from 8
    step(1'b0, 1'b0, 4'd0, 16'h0, 4'd5, 16'h0100, 1'b1);      // respawn at r
    chk("respawn_hit", 0, 32'(if0.hit), 32'd0);
    idle(1);
    hit5();                                   // r+2
    chk("resp_grace_hit", 0, 32'(if0.hit), 32'd0);
    idle(6);
    hit5();                                   // r+9
    chk("resp_watch_hit", 0, 32'(if0.hit), 32'd1);
    chk("resp_watch_row", 0, 32'(if0.hit_row), 32'd5);
`else
    idle(10);
    hit5();
    chk("l1_life_lost", 0, 32'(if0.life_lost), 32'd1);
    chk("l1_lives", 0, 32'(if0.lives_left), 32'd2);
    chk("l1_hit", 0, 32'(if0.hit), 32'd0);
    idle(1);
    chk("l1_pulse_end", 0, 32'(if0.life_lost), 32'd0);
    idle(9);
    hit5();
    chk("l2_life_lost", 0, 32'(if0.life_lost), 32'd1);
    chk("l2_lives", 0, 32'(if0.lives_left), 32'd1);
    chk("l2_hit", 0, 32'(if0.hit), 32'd0);
    idle(10);
    hit5();
    chk("l3_life_lost", 0, 32'(if0.life_lost), 32'd0);
    chk("l3_lives", 0, 32'(if0.lives_left), 32'd0);
    chk("l3_hit", 0, 32'(if0.hit), 32'd1);
    chk("l3_row", 0, 32'(if0.hit_row), 32'd5);
`endif

    // Randomized phase, biased toward the frog's row and sparse hazards.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  fr;
      logic [3:0]  ri;
      logic [15:0] fp;
      fr = 4'($urandom_range(15));
      ri = ($urandom_range(1) == 0) ? fr : 4'($urandom_range(15));
      fp = 16'(1 << $urandom_range(15));
      if ($urandom_range(3) == 0) fp = fp | 16'($urandom);
      step($urandom_range(60) == 0, $urandom_range(3) != 0, ri,
           16'($urandom) & 16'($urandom) & 16'($urandom), fr, fp,
           $urandom_range(15) == 0);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
